// File: rtl/seq_divider_if.sv
// Operand/result bundle between the operation decoder (master) and the divider (slave).
// Handshake: start is sampled only while busy is low; busy covers the whole operation; done pulses once when results are valid.
interface seq_divider_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, signed_mode, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signed_mode, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, signed/unsigned per operation.
// Produces quotient and remainder; division by zero skips the core and raises div_by_zero.
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   seq_divider_if.slave bus,
   output logic [1:0]   o_dbg_state
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_dvd_raw;
   logic             r_dbz;
   logic             r_neg_q;
   logic             r_neg_r;

   logic             r_done;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_by_zero;

   logic             w_dvd_neg;
   logic             w_dvs_neg;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dvs_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_diff;
   logic             w_fits;
   logic             w_last;
   logic [WIDTH-1:0] w_rem_lo;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   // The core always works on magnitudes; the signs are reapplied in FINISH.
   assign w_dvd_neg = bus.signed_mode & bus.dividend[WIDTH-1];
   assign w_dvs_neg = bus.signed_mode & bus.divisor[WIDTH-1];
   assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
   assign w_dvs_mag = w_dvs_neg ? -bus.divisor  : bus.divisor;

   // r_quo starts as the dividend and is shifted out MSB-first while quotient bits shift in.
   assign w_shift  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
   assign w_diff   = {1'b0, w_shift} - {2'b00, r_dvs};
   assign w_fits   = ~w_diff[WIDTH+1];
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   assign w_rem_lo = r_rem[WIDTH-1:0];
   assign w_q_fix  = r_neg_q ? -r_quo    : r_quo;
   assign w_r_fix  = r_neg_r ? -w_rem_lo : w_rem_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_next = (bus.divisor == '0) ? ST_FINISH : ST_CALC;
            end
         end
         ST_CALC: begin
            if (w_last) begin
               w_next = ST_FINISH;
            end
         end
         ST_FINISH: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_rem         <= '0;
         r_quo         <= '0;
         r_dvs         <= '0;
         r_dvd_raw     <= '0;
         r_dbz         <= 1'b0;
         r_neg_q       <= 1'b0;
         r_neg_r       <= 1'b0;
         r_done        <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_cnt     <= '0;
                  r_rem     <= '0;
                  r_quo     <= w_dvd_mag;
                  r_dvs     <= w_dvs_mag;
                  r_dvd_raw <= bus.dividend;
                  r_dbz     <= (bus.divisor == '0);
                  r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                  r_neg_r   <= w_dvd_neg;
               end
            end
            ST_CALC: begin
               r_cnt <= r_cnt + CW'(1);
               r_rem <= w_fits ? w_diff[WIDTH:0] : w_shift;
               r_quo <= {r_quo[WIDTH-2:0], w_fits};
            end
            ST_FINISH: begin
               r_done <= 1'b1;
               if (r_dbz) begin
                  r_quotient    <= '1;
                  r_remainder   <= r_dvd_raw;
                  r_div_by_zero <= 1'b1;
               end else begin
                  r_quotient    <= w_q_fix;
                  r_remainder   <= w_r_fix;
                  r_div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.done        = r_done;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_div_by_zero;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider (WIDTH=16) against an arithmetic reference model.
module tb_seq_divider;

   localparam int W = 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_q[$];
   logic         exp_z[$];

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Reference: plain integer division; SV signed / and % truncate toward zero.
   function automatic void model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      longint sa, sb;
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else if (sm) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = W'(sa / sb);
         r  = W'(sa % sb);
         z  = 1'b0;
      end else begin
         q = a / b;
         r = a % b;
         z = 1'b0;
      end
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] q, r;
      logic         z;
      model(sm, a, b, q, r, z);
      exp_q.push_back(q);
      exp_q.push_back(r);
      exp_z.push_back(z);
      bus.signed_mode = sm;
      bus.dividend    = a;
      bus.divisor     = b;
      bus.start       = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("busy_after_accept", 64'(bus.busy), 64'd1);
      check("done_low_after_accept", 64'(bus.done), 64'd0);
   endtask

   task automatic wait_done(input string tag, input int lat, input bit pulse);
      int           n;
      bit           seen;
      logic [W-1:0] q, r;
      logic         z;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.done) begin
            seen = 1'b1;
         end else begin
            check({tag, "_busy_in_flight"}, 64'(bus.busy), 64'd1);
            bus.dividend    = W'($urandom);
            bus.divisor     = W'($urandom);
            bus.signed_mode = 1'($urandom_range(0, 1));
            bus.start       = pulse && (n == 3 || n == 10);
         end
      end
      bus.start = 1'b0;
      check({tag, "_latency"}, 64'(n), 64'(lat));
      check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
      q = exp_q.pop_front();
      r = exp_q.pop_front();
      z = exp_z.pop_front();
      check({tag, "_quotient"}, 64'(bus.quotient), 64'(q));
      check({tag, "_remainder"}, 64'(bus.remainder), 64'(r));
      check({tag, "_div_by_zero"}, 64'(bus.div_by_zero), 64'(z));
   endtask

   task automatic done_fall(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check({tag, "_done"}, 64'(bus.done), 64'd0);
      check({tag, "_quotient"}, 64'(bus.quotient), 64'd0);
      check({tag, "_remainder"}, 64'(bus.remainder), 64'd0);
      check({tag, "_div_by_zero"}, 64'(bus.div_by_zero), 64'd0);
   endtask

   initial begin
      logic         sm;
      logic [W-1:0] a, b;
      bit           chained;

      bus.start       = 1'b0;
      bus.signed_mode = 1'b0;
      bus.dividend    = '0;
      bus.divisor     = '0;

      // Clock/reset
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Unsigned basic and divide-by-zero followed by a clean operation
      issue(1'b0, 16'd100, 16'd7);
      wait_done("u100_7", 17, 1'b0);
      done_fall("u100_7");
      issue(1'b0, 16'd5, 16'd0);
      wait_done("dz5", 1, 1'b0);
      done_fall("dz5");
      issue(1'b0, 16'd9, 16'd3);
      wait_done("u9_3", 17, 1'b0);
      done_fall("u9_3");

      // Signed truncation and the MIN / -1 wrap
      issue(1'b1, 16'hFFF9, 16'd2);
      wait_done("s_m7_2", 17, 1'b0);
      done_fall("s_m7_2");
      issue(1'b1, 16'd7, 16'hFFFE);
      wait_done("s_7_m2", 17, 1'b0);
      done_fall("s_7_m2");
      issue(1'b1, 16'h8000, 16'hFFFF);
      wait_done("s_min_m1", 17, 1'b0);
      done_fall("s_min_m1");
      issue(1'b1, 16'h8001, 16'd0);
      wait_done("s_dz_neg", 1, 1'b0);
      done_fall("s_dz_neg");

      // All-ones dividend by one, both modes
      issue(1'b0, 16'hFFFF, 16'd1);
      wait_done("u_ffff_1", 17, 1'b0);
      done_fall("u_ffff_1");
      issue(1'b1, 16'hFFFF, 16'd1);
      wait_done("s_ffff_1", 17, 1'b0);
      done_fall("s_ffff_1");

      // start re-pulsed while busy, then start held in the done cycle
      issue(1'b0, 16'd1000, 16'd33);
      wait_done("repulse", 17, 1'b1);
      issue(1'b1, 16'hFED4, 16'd7);
      wait_done("b2b", 17, 1'b0);
      done_fall("b2b");

      // Reset mid-operation
      issue(1'b0, 16'd1234, 16'd5);
      for (int i = 1; i < 8; i++) begin
         @(posedge clk);
         #1;
         check("pre_reset_busy", 64'(bus.busy), 64'd1);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("mid_reset");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("mid_reset_no_done", 64'(bus.done), 64'd0);
      end
      exp_q.delete();
      exp_z.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(1'b0, 16'd50, 16'd5);
      wait_done("after_reset", 17, 1'b0);
      done_fall("after_reset");

      // Randomized operations, sometimes issued back-to-back in the done cycle
      chained = 1'b0;
      for (int t = 0; t < 40; t++) begin
         sm = 1'($urandom_range(0, 1));
         a  = W'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            b = '0;
         end else if ($urandom_range(0, 3) == 0) begin
            b = W'($urandom_range(1, 15));
         end else begin
            b = W'($urandom);
         end
         issue(sm, a, b);
         wait_done("rand", (b == '0) ? 1 : 17, 1'b0);
         chained = 1'($urandom_range(0, 1));
         if (!chained) begin
            done_fall("rand");
         end
      end
      if (chained) begin
         done_fall("rand_last");
      end

      $display("final dbg_state=%0d", dbg_state);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
